// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop input synchronizer, single mid-bit sample per bit,
// one-cycle valid / frame_error pulses, break (line held low) absorbed in WAIT_HIGH.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       udata,
    output logic [7:0] out,
    output logic       valid,
    output logic       busy,
    output logic       frame_error
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [12:0] BIT_END  = 13'(CLKS_PER_BIT - 1);
    localparam logic [12:0] HALF_END = 13'(CLKS_PER_BIT / 2 - 1);

    state_t      state, state_next;
    logic        sync1, rx;
    logic [12:0] cnt, cnt_next;
    logic [2:0]  idx, idx_next;
    logic [7:0]  shreg, shreg_next;
    logic [7:0]  out_next;
    logic        valid_next, ferr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b1;
            rx          <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            out         <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            sync1       <= udata;
            rx          <= sync1;
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shreg       <= shreg_next;
            out         <= out_next;
            valid       <= valid_next;
            frame_error <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        out_next   = out;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx) state_next = START;
            end
            START: begin
                // Half a bit in: confirm the start bit is still low, else treat as a glitch.
                if (cnt == HALF_END) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rx ? IDLE : DATA;
                end else begin
                    cnt_next = cnt + 13'd1;
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    shreg_next[idx] = rx;
                    cnt_next        = '0;
                    idx_next        = idx + 3'd1;
                    if (idx == 3'd7) state_next = STOP;
                end else begin
                    cnt_next = cnt + 13'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_next = '0;
                    if (rx) begin
                        out_next   = shreg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt + 13'd1;
                end
            end
            WAIT_HIGH: begin
                cnt_next = '0;
                if (rx) state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 16 clocks per bit: stimulus pushes expected
// valid / frame_error events, a negedge monitor pops and compares them.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       udata;
    logic [7:0] out;
    logic       valid;
    logic       busy;
    logic       frame_error;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .udata       (udata),
        .out         (out),
        .valid       (valid),
        .busy        (busy),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] last_out = 8'h00;
    logic       send_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected event per output pulse and checks output invariants.
    logic [7:0] prev_out = 8'h00;
    logic       prev_rst = 1'b1;
    logic       prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1 && frame_error === 1'b1)
            check("valid_and_ferr_together", 1, 0);
        if (valid === 1'b1 || frame_error === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {valid, frame_error}, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind_ferr", frame_error, e.err);
                check("out_at_pulse", out, e.data);
            end
        end
        if (prev_valid) check("busy_after_valid", busy, 0);
        if (!prev_rst && valid !== 1'b1 && out !== prev_out)
            check("out_changed_without_valid", out, prev_out);
        prev_out   = out;
        prev_rst   = rst;
        prev_valid = (valid === 1'b1);
    end

    task automatic drive_bit(input logic b);
        udata = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        if (stop) begin
            e.err = 1'b0; e.data = d; last_out = d;
        end else begin
            e.err = 1'b1; e.data = last_out;
        end
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        udata = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int cyc;
        rst   = 1'b1;
        udata = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out", out, 8'h00);
        check("reset_valid", valid, 0);
        check("reset_ferr", frame_error, 0);
        check("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        idle(10);

        // single byte
        send_frame(8'hA5, 1'b1);
        idle(20);
        drain("a5_received");
        check("a5_out_hold", out, 8'hA5);

        // back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        drain("b2b_received");
        check("b2b_out_final", out, 8'hFF);

        // false start: 4-clock low glitch
        udata = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(30);
        check("false_start_busy", busy, 0);
        check("false_start_out", out, last_out);

        // stop bit low followed by a break
        send_frame(8'h3C, 1'b0);
        udata = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("break_busy_high", busy, 1);
        repeat (20) @(posedge clk);
        #1;
        check("break_busy_still_high", busy, 1);
        drain("break_ferr_seen");
        idle(6);
        check("break_busy_released", busy, 0);
        check("break_out_kept", out, 8'hFF);
        idle(10);
        send_frame(8'h55, 1'b1);
        idle(20);
        drain("after_break_55");

        // reset in the middle of data bit 4
        udata = 1'b0; repeat (CPB) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        udata = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        #1;
        udata = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_out = 8'h00;
        @(negedge clk);
        check("midrst_out", out, 8'h00);
        check("midrst_valid", valid, 0);
        check("midrst_ferr", frame_error, 0);
        check("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        idle(2 * CPB);
        check("midrst_idle_busy", busy, 0);
        send_frame(8'h81, 1'b1);
        idle(20);
        drain("after_rst_81");
        check("after_rst_out", out, 8'h81);

        // latency from start edge to valid
        idle(10);
        send_done = 1'b0;
        fork
            begin
                send_frame(8'h5A, 1'b1);
                send_done = 1'b1;
            end
        join_none
        wait (udata == 1'b0);
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (valid === 1'b1) break;
        end
        compared++;
        if (cyc < 2 + CPB / 2 + 9 * CPB - 1 || cyc > 2 + CPB / 2 + 9 * CPB + 1) begin
            mismatched++;
            $display("FAIL latency_5a: got %0d clocks, required %0d +-1", cyc, 2 + CPB / 2 + 9 * CPB);
        end
        wait (send_done == 1'b1);
        idle(20);
        drain("latency_5a_received");
        check("latency_out", out, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clocks per serial bit (50 MHz / 9600 baud); legal range 8..8191.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port udata  input  1  asynchronous serial line, idles high, 8N1 framing, LSB first.
REQ-005 SHALL have port out  output  8  last correctly framed received byte.
REQ-006 SHALL have port valid  output  1  one-cycle pulse when out has just been updated.
REQ-007 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 SHALL have port frame_error  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-009 SHALL pass udata through a 2-flop synchronizer (reset value 1,1); all logic below uses the synchronized signal rx.
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-011 SHALL use a 13-bit baud counter, a 3-bit bit index and an 8-bit shift register.
REQ-012 IDLE: baud counter held at 0; on rx == 0 -> START with baud counter cleared.
REQ-013 START: count to CLKS_PER_BIT/2 - 1 (integer division); then sample rx: 0 -> DATA, counter cleared, bit index 0; 1 -> IDLE (false start, no pulse).
REQ-014 DATA: each time the counter reaches CLKS_PER_BIT - 1, sample rx into shift register bit [bit index] (LSB first), clear the counter, increment the index; after index 7 is sampled -> STOP.
REQ-015 STOP: when the counter reaches CLKS_PER_BIT - 1, sample rx: 1 -> load out from shift register, pulse valid, -> IDLE; 0 -> pulse frame_error, out unchanged, -> WAIT_HIGH.
REQ-016 WAIT_HIGH: stay until rx == 1, then -> IDLE; no pulses while waiting (break condition).
REQ-017 valid and frame_error SHALL each be high for exactly one clock per frame and SHALL never be high together.
REQ-018 out SHALL hold its value between frames and SHALL change only in the cycle valid is asserted.
REQ-019 Latency: valid asserts 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks (+-1) after the udata falling edge of the start bit, i.e. mid stop bit.
REQ-020 A start edge arriving in the cycle the FSM returns to IDLE SHALL be accepted on the next cycle; back-to-back frames with one stop bit SHALL be received without loss.
REQ-021 rx transitions inside a bit period other than at the sample point SHALL be ignored (single mid-bit sample, no oversampling vote).
REQ-022 Baud counter SHALL never exceed CLKS_PER_BIT - 1; no wrap-around past 13 bits.

Reset
REQ-023 rst high SHALL, at the next clock edge, force state IDLE, baud counter 0, bit index 0, shift register 0x00, out 0x00, valid 0, frame_error 0, busy 0, synchronizer flops 1.
REQ-024 rst asserted mid-frame SHALL abandon the frame without valid or frame_error; reception resumes on the first falling edge after rst deasserts.

Verification (CLKS_PER_BIT = 16 for simulation)
REQ-025 Send 0xA5 with correct framing -> exactly one valid pulse, out == 0xA5, frame_error never high, busy low one cycle after valid.
REQ-026 Send 0x00 then 0xFF back-to-back, no idle gap -> two valid pulses, out == 0x00 then 0xFF.
REQ-027 Pull udata low for 4 clocks then high -> FSM returns to IDLE from START, no valid, no frame_error, out unchanged.
REQ-028 Send 0x3C with stop bit forced low, line held low 40 clocks, then high -> one frame_error pulse, no valid, out keeps prior value, busy high until line returns high; then 0x55 received correctly.
REQ-029 Assert rst for one clock during bit 4 of a frame -> all outputs at reset values, no pulses; next full frame 0x81 -> out == 0x81.
REQ-030 Measure latency of 0x5A from udata start edge to valid -> 2 + 8 + 144 clocks, +-1.
